// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters: zero-latency fetch lookup,
// execute-stage training, misprediction redirect and saturating branch/miss statistics.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 24
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST_N,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        UpdateE,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE,
    output logic [31:0] BranchCnt,
    output logic [31:0] MissCnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] w_idx_f;
    logic [INDEX_BITS-1:0] w_idx_e;
    logic [TAG_BITS-1:0]   w_tag_f;
    logic [TAG_BITS-1:0]   w_tag_e;
    logic                  w_hit_f;
    logic                  w_hit_e;
    logic                  w_unused_pc_bits;

    assign w_idx_f          = PCF[INDEX_BITS+1:2];
    assign w_tag_f          = PCF[31:INDEX_BITS+2];
    assign w_idx_e          = PCE[INDEX_BITS+1:2];
    assign w_tag_e          = PCE[31:INDEX_BITS+2];
    assign w_unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    // Fetch-side lookup; reads pre-edge table contents, no bypass from the update port
    always_comb begin
        w_hit_f     = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
        PredTakenF  = 1'b0;
        PredTargetF = 32'd0;
        if (w_hit_f && r_ctr[w_idx_f][1]) begin
            PredTakenF  = 1'b1;
            PredTargetF = r_target[w_idx_f];
        end else begin
            PredTakenF  = 1'b0;
            PredTargetF = 32'd0;
        end
    end

    // Execute-side hit test and redirect decision
    always_comb begin
        w_hit_e     = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
        MispredictE = UpdateE && ((PredTakenE != BranchE) ||
                                  (BranchE && (PredTargetE != BrTargetE)));
        if (BranchE) begin
            CorrectPCE = BrTargetE;
        end else begin
            CorrectPCE = PCE + 32'd4;
        end
    end

    // Table training; not-taken misses never allocate so resident aliases survive
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_valid <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= {TAG_BITS{1'b0}};
                r_target[i] <= 32'd0;
                r_ctr[i]    <= 2'b00;
            end
        end else if (UpdateE) begin
            if (w_hit_e) begin
                if (BranchE) begin
                    r_ctr[w_idx_e]    <= ctr_inc(r_ctr[w_idx_e]);
                    r_target[w_idx_e] <= BrTargetE;
                end else begin
                    r_ctr[w_idx_e]    <= ctr_dec(r_ctr[w_idx_e]);
                end
            end else if (BranchE) begin
                r_valid[w_idx_e]  <= 1'b1;
                r_tag[w_idx_e]    <= w_tag_e;
                r_target[w_idx_e] <= BrTargetE;
                r_ctr[w_idx_e]    <= 2'b10;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            BranchCnt <= 32'd0;
            MissCnt   <= 32'd0;
        end else begin
            if (UpdateE && (BranchCnt != 32'hFFFF_FFFF)) begin
                BranchCnt <= BranchCnt + 32'd1;
            end
            if (MispredictE && (MissCnt != 32'hFFFF_FFFF)) begin
                MissCnt <= MissCnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations are queued as stimulus is driven
// and popped/compared when the DUT output is sampled.
module tb_branch_predictor;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdateE;
    logic [31:0] PCE;
    logic        BranchE;
    logic [31:0] BrTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] CorrectPCE;
    logic [31:0] BranchCnt;
    logic [31:0] MissCnt;

    typedef struct {
        logic        mis;
        logic [31:0] cpc;
    } ex_exp_t;

    typedef struct {
        logic        taken;
        logic [31:0] tgt;
    } if_exp_t;

    ex_exp_t ex_q[$];
    if_exp_t if_q[$];
    ex_exp_t ee;
    if_exp_t fe;
    int total = 0;
    int bad   = 0;
    int exp_bc = 0;
    int exp_mc = 0;

    branch_predictor dut (
        .CPU_CLK    (CPU_CLK),
        .CPU_RST_N  (CPU_RST_N),
        .PCF        (PCF),
        .PredTakenF (PredTakenF),
        .PredTargetF(PredTargetF),
        .UpdateE    (UpdateE),
        .PCE        (PCE),
        .BranchE    (BranchE),
        .BrTargetE  (BrTargetE),
        .PredTakenE (PredTakenE),
        .PredTargetE(PredTargetE),
        .MispredictE(MispredictE),
        .CorrectPCE (CorrectPCE),
        .BranchCnt  (BranchCnt),
        .MissCnt    (MissCnt)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // Drive one EX-stage branch and queue its expected redirect and statistics effect
    task automatic drive_ex(input logic upd, input logic [31:0] pce, input logic br,
                            input logic [31:0] btgt, input logic pt, input logic [31:0] ptgt,
                            input logic exp_mis, input logic [31:0] exp_cpc);
        UpdateE = upd; PCE = pce; BranchE = br; BrTargetE = btgt;
        PredTakenE = pt; PredTargetE = ptgt;
        ex_q.push_back('{exp_mis, exp_cpc});
        if (upd) exp_bc++;
        if (exp_mis) exp_mc++;
    endtask

    task automatic advance();
        @(posedge CPU_CLK); #1;
        UpdateE = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        PCF = pc;
        if_q.push_back('{taken, tgt});
        #1;
    endtask

    task automatic test_reset();
        CPU_RST_N = 1'b0; UpdateE = 1'b0; PCE = 32'd0; BranchE = 1'b0; BrTargetE = 32'd0;
        PredTakenE = 1'b0; PredTargetE = 32'd0; PCF = 32'd0;
        #12;
        @(posedge CPU_CLK); #1;
        CPU_RST_N = 1'b1;
        lookup(32'h40, 1'b0, 32'd0);
        fe = if_q.pop_front(); total++;
        if (PredTakenF !== fe.taken) begin $display("FAIL reset_taken got=%b exp=%b", PredTakenF, fe.taken); bad++; end
        total++;
        if (PredTargetF !== fe.tgt) begin $display("FAIL reset_target got=%h exp=%h", PredTargetF, fe.tgt); bad++; end
        total++;
        if (BranchCnt !== 32'(exp_bc)) begin $display("FAIL reset_bcnt got=%0d exp=%0d", BranchCnt, exp_bc); bad++; end
        total++;
        if (MissCnt !== 32'(exp_mc)) begin $display("FAIL reset_mcnt got=%0d exp=%0d", MissCnt, exp_mc); bad++; end
    endtask

    task automatic test_allocate();
        drive_ex(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 32'h100);
        @(negedge CPU_CLK);
        ee = ex_q.pop_front(); total++;
        if (MispredictE !== ee.mis) begin $display("FAIL alloc_mis got=%b exp=%b", MispredictE, ee.mis); bad++; end
        total++;
        if (CorrectPCE !== ee.cpc) begin $display("FAIL alloc_cpc got=%h exp=%h", CorrectPCE, ee.cpc); bad++; end
        advance();
        lookup(32'h40, 1'b1, 32'h100);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL alloc_lookup got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        total++;
        if ({BranchCnt, MissCnt} !== {32'(exp_bc), 32'(exp_mc)}) begin
            $display("FAIL alloc_counts got=%0d/%0d exp=%0d/%0d", BranchCnt, MissCnt, exp_bc, exp_mc); bad++;
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 2; i++) begin
            drive_ex(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100);
            @(negedge CPU_CLK);
            ee = ex_q.pop_front(); total++;
            if (MispredictE !== ee.mis) begin $display("FAIL sat_taken_mis%0d got=%b exp=%b", i, MispredictE, ee.mis); bad++; end
            advance();
        end
        drive_ex(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);
        @(negedge CPU_CLK);
        ee = ex_q.pop_front(); total++;
        if ({MispredictE, CorrectPCE} !== {ee.mis, ee.cpc}) begin
            $display("FAIL sat_nt1 got=%b/%h exp=%b/%h", MispredictE, CorrectPCE, ee.mis, ee.cpc); bad++;
        end
        advance();
        lookup(32'h40, 1'b1, 32'h100);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL sat_after_nt1 got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        drive_ex(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);
        @(negedge CPU_CLK);
        ee = ex_q.pop_front(); total++;
        if ({MispredictE, CorrectPCE} !== {ee.mis, ee.cpc}) begin
            $display("FAIL sat_nt2 got=%b/%h exp=%b/%h", MispredictE, CorrectPCE, ee.mis, ee.cpc); bad++;
        end
        advance();
        lookup(32'h40, 1'b0, 32'd0);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL sat_after_nt2 got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
    endtask

    task automatic test_alias();
        // ctr 01 -> 10 so the resident 0x40 entry predicts taken again
        drive_ex(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 32'h100);
        advance();
        void'(ex_q.pop_front());
        drive_ex(1'b1, 32'h1040, 1'b0, 32'h200, 1'b0, 32'd0, 1'b0, 32'h1044);
        @(negedge CPU_CLK);
        ee = ex_q.pop_front(); total++;
        if ({MispredictE, CorrectPCE} !== {ee.mis, ee.cpc}) begin
            $display("FAIL alias_nt_ex got=%b/%h exp=%b/%h", MispredictE, CorrectPCE, ee.mis, ee.cpc); bad++;
        end
        advance();
        lookup(32'h40, 1'b1, 32'h100);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL alias_nt_keep got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        drive_ex(1'b1, 32'h1040, 1'b1, 32'h200, 1'b0, 32'd0, 1'b1, 32'h200);
        advance();
        void'(ex_q.pop_front());
        lookup(32'h40, 1'b0, 32'd0);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL alias_old_evicted got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        lookup(32'h1040, 1'b1, 32'h200);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL alias_new got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
    endtask

    task automatic test_wrong_target();
        drive_ex(1'b1, 32'h1040, 1'b1, 32'h280, 1'b1, 32'h200, 1'b1, 32'h280);
        @(negedge CPU_CLK);
        ee = ex_q.pop_front(); total++;
        if ({MispredictE, CorrectPCE} !== {ee.mis, ee.cpc}) begin
            $display("FAIL wtgt_ex got=%b/%h exp=%b/%h", MispredictE, CorrectPCE, ee.mis, ee.cpc); bad++;
        end
        advance();
        lookup(32'h1040, 1'b1, 32'h280);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL wtgt_stored got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        // A disagreeing EX slot with UpdateE low is a bubble: no redirect, no count, no training
        drive_ex(1'b0, 32'h1040, 1'b0, 32'h0, 1'b1, 32'h280, 1'b0, 32'h1044);
        @(negedge CPU_CLK);
        ee = ex_q.pop_front(); total++;
        if ({MispredictE, CorrectPCE} !== {ee.mis, ee.cpc}) begin
            $display("FAIL bubble_ex got=%b/%h exp=%b/%h", MispredictE, CorrectPCE, ee.mis, ee.cpc); bad++;
        end
        advance();
        lookup(32'h1040, 1'b1, 32'h280);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL bubble_keep got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        total++;
        if ({BranchCnt, MissCnt} !== {32'(exp_bc), 32'(exp_mc)}) begin
            $display("FAIL wtgt_counts got=%0d/%0d exp=%0d/%0d", BranchCnt, MissCnt, exp_bc, exp_mc); bad++;
        end
    endtask

    task automatic test_back_to_back();
        drive_ex(1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'd0, 1'b1, 32'h300);
        PCF = 32'h80;
        if_q.push_back('{1'b0, 32'd0});
        @(negedge CPU_CLK);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL b2b_same_cycle got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        void'(ex_q.pop_front());
        @(posedge CPU_CLK); #1;
        drive_ex(1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h300);
        if_q.push_back('{1'b1, 32'h300});
        @(negedge CPU_CLK);
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL b2b_next_cycle got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        ee = ex_q.pop_front(); total++;
        if (MispredictE !== ee.mis) begin $display("FAIL b2b_correct_mis got=%b exp=%b", MispredictE, ee.mis); bad++; end
        advance();
        total++;
        if ({BranchCnt, MissCnt} !== {32'(exp_bc), 32'(exp_mc)}) begin
            $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", BranchCnt, MissCnt, exp_bc, exp_mc); bad++;
        end
    endtask

    task automatic test_async_reset();
        #2;
        CPU_RST_N = 1'b0;
        exp_bc = 0; exp_mc = 0;
        drive_ex(1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'd0, 1'b1, 32'h300);
        if_q.push_back('{1'b0, 32'd0});
        #1;
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL arst_lookup got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        total++;
        if ({BranchCnt, MissCnt} !== 64'd0) begin
            $display("FAIL arst_counts got=%0d/%0d exp=0/0", BranchCnt, MissCnt); bad++;
        end
        ee = ex_q.pop_front(); total++;
        if ({MispredictE, CorrectPCE} !== {ee.mis, ee.cpc}) begin
            $display("FAIL arst_mis got=%b/%h exp=%b/%h", MispredictE, CorrectPCE, ee.mis, ee.cpc); bad++;
        end
        // Edge while reset is held must not train or count
        @(posedge CPU_CLK); #1;
        total++;
        if ({PredTakenF, BranchCnt, MissCnt} !== 65'd0) begin
            $display("FAIL arst_held got=%b/%0d/%0d exp=0/0/0", PredTakenF, BranchCnt, MissCnt); bad++;
        end
        CPU_RST_N = 1'b1;
        exp_bc = 1; exp_mc = 1;
        if_q.push_back('{1'b1, 32'h300});
        advance();
        fe = if_q.pop_front(); total++;
        if ({PredTakenF, PredTargetF} !== {fe.taken, fe.tgt}) begin
            $display("FAIL arst_first_update got=%b/%h exp=%b/%h", PredTakenF, PredTargetF, fe.taken, fe.tgt); bad++;
        end
        total++;
        if ({BranchCnt, MissCnt} !== {32'(exp_bc), 32'(exp_mc)}) begin
            $display("FAIL arst_first_counts got=%0d/%0d exp=%0d/%0d", BranchCnt, MissCnt, exp_bc, exp_mc); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_alias();
        test_wrong_target();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
